// File: rtl/uart_rx_set_config_pkg.sv
// Shared constants for the UART receive / config-set path: command bytes,
// default bit divider and the RX and parser state encodings.
package uart_rx_set_config_pkg;

   localparam int BIT_DIV_DEFAULT = 87;

   localparam logic [7:0] CMD_SET     = 8'h53;
   localparam logic [7:0] CMD_DEFAULT = 8'h44;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [0:0] P_IDLE    = 1'b0;
   localparam logic [0:0] P_COLLECT = 1'b1;

   function automatic int nbytes_for(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_rx_set_config_rx_only.sv
// 8N1 UART receiver clocked directly from clk10mhz; one bit every BIT_DIV
// cycles, sampled mid-bit after a half-bit start-bit qualification.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronised falling edge
// RX_START | counting to mid start bit, re-checking it is still low
// RX_DATA  | sampling 8 data bits LSB first, one per BIT_DIV cycles
// RX_STOP  | sampling the stop bit; high loads rxData8, low flags an error
module uart_rx_only
   import uart_rx_set_config_pkg::*;
#(
   parameter int BIT_DIV = BIT_DIV_DEFAULT
) (
   input  logic       clk10mhz,
   input  logic       nRst,
   input  logic       uRx,
   output logic [7:0] rxData8,
   output logic       rxValid,
   output logic       rxFrameErr
);

   localparam int               CNT_W    = $clog2(BIT_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_DIV / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

   logic             sync1_q, sync2_q, prev_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   // Synchroniser flops reset high so a held-low reset never looks like a start bit
   always_ff @(posedge clk10mhz or negedge nRst) begin
      if (!nRst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= uRx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (prev_q && !sync2_q) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!sync2_q) begin
                  state_d   = RX_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = RX_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (sync2_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk10mhz or negedge nRst) begin
      if (!nRst) begin
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rxData8    = data_q;
   assign rxValid    = valid_q;
   assign rxFrameErr = ferr_q;

endmodule

// File: rtl/uart_rx_set_config.sv
// UART command parser driving the configuration bus: 'S' + N bytes sets
// busNow, 'D' reverts busNow to busDefault.
//
// state     | meaning
// P_IDLE    | waiting for a command byte ('S' or 'D')
// P_COLLECT | staging payload bytes LSB lane first, under inter-byte timeout
module uart_rx_set_config
   import uart_rx_set_config_pkg::*;
#(
   parameter int BIT_DIV  = BIT_DIV_DEFAULT,
   parameter int busWIDTH = 8,
   parameter int TMO_BITS = 20
) (
   input  logic                clk10mhz,
   input  logic                nRst,
   input  logic                uRx,
   input  logic [busWIDTH-1:0] busDefault,
   output logic [busWIDTH-1:0] busNow,
   output logic [7:0]          rxData8,
   output logic                rxValid,
   output logic                rxFrameErr,
   output logic                cfgUpdated
);

   localparam int               NBYTES    = nbytes_for(busWIDTH);
   localparam int               STG_W     = NBYTES * 8;
   localparam int               TMO_LIMIT = TMO_BITS * BIT_DIV;
   localparam int               TMO_W     = $clog2(TMO_LIMIT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TMO_LIMIT);
   localparam logic [1:0]       LAST_IDX  = 2'(NBYTES - 1);

   logic [0:0]          pstate_q, pstate_d;
   logic [1:0]          idx_q, idx_d;
   logic [STG_W-1:0]    stage_q, stage_d, stage_wr;
   logic [busWIDTH-1:0] cfg_q, cfg_d;
   logic                use_def_q, use_def_d;
   logic                upd_q, upd_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;

   uart_rx_only #(
      .BIT_DIV (BIT_DIV)
   ) u_rx (
      .clk10mhz   (clk10mhz),
      .nRst       (nRst),
      .uRx        (uRx),
      .rxData8    (rxData8),
      .rxValid    (rxValid),
      .rxFrameErr (rxFrameErr)
   );

   always_comb begin
      stage_wr = stage_q;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx_q == 2'(i)) begin
            stage_wr[i*8 +: 8] = rxData8;
         end
      end
   end

   // A byte arriving on the same cycle the timer expires is still consumed
   always_comb begin
      pstate_d  = pstate_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      cfg_d     = cfg_q;
      use_def_d = use_def_q;
      upd_d     = 1'b0;
      tmo_d     = tmo_q;
      case (pstate_q)
         P_IDLE: begin
            tmo_d = '0;
            if (rxValid) begin
               if (rxData8 == CMD_SET) begin
                  pstate_d = P_COLLECT;
                  idx_d    = '0;
                  stage_d  = '0;
               end else if (rxData8 == CMD_DEFAULT) begin
                  use_def_d = 1'b1;
                  upd_d     = 1'b1;
               end
            end
         end
         P_COLLECT: begin
            if (rxValid) begin
               tmo_d = '0;
               if (idx_q == LAST_IDX) begin
                  cfg_d     = stage_wr[busWIDTH-1:0];
                  use_def_d = 1'b0;
                  upd_d     = 1'b1;
                  pstate_d  = P_IDLE;
               end else begin
                  stage_d = stage_wr;
                  idx_d   = idx_q + 1'b1;
               end
            end else if (rxFrameErr || (tmo_q == TMO_MAX)) begin
               pstate_d = P_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            pstate_d = P_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk10mhz or negedge nRst) begin
      if (!nRst) begin
         pstate_q  <= P_IDLE;
         idx_q     <= '0;
         stage_q   <= '0;
         cfg_q     <= '0;
         use_def_q <= 1'b1;
         upd_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         pstate_q  <= pstate_d;
         idx_q     <= idx_d;
         stage_q   <= stage_d;
         cfg_q     <= cfg_d;
         use_def_q <= use_def_d;
         upd_q     <= upd_d;
         tmo_q     <= tmo_d;
      end
   end

   assign busNow     = use_def_q ? busDefault : cfg_q;
   assign cfgUpdated = upd_q;

endmodule

// File: tb/tb_uart_rx_set_config.sv
// Bench for uart_rx_set_config: an 8-bit and a 16-bit instance share one
// serial line and are checked against a byte-level command model.
module tb_uart_rx_set_config;

   localparam int BIT_DIV   = 87;
   localparam int TMO_BITS  = 20;
   // Idle time between frames beyond which the inter-byte timer has expired
   localparam int GAP_LIMIT = TMO_BITS * BIT_DIV - 10 * BIT_DIV;

   logic        clk = 1'b0;
   logic        nRst;
   logic        uRx;
   logic [15:0] bus_def;
   logic [7:0]  bus_now_a, data_a, data_b;
   logic [15:0] bus_now_b;
   logic        valid_a, ferr_a, upd_a, valid_b, ferr_b, upd_b;

   int checks = 0;
   int errors = 0;
   int cnt_va = 0, cnt_fa = 0, cnt_ua = 0, cnt_vb = 0, cnt_fb = 0, cnt_ub = 0;
   bit settled = 1'b0;

   int          width_of [2] = '{8, 16};
   bit          m_usedef [2];
   bit          m_collect[2];
   int          m_got    [2];
   logic [31:0] m_stage  [2];
   logic [31:0] m_cfg    [2];
   logic [7:0]  m_data;

   always #5 clk = ~clk;

   uart_rx_set_config #(.BIT_DIV(BIT_DIV), .busWIDTH(8), .TMO_BITS(TMO_BITS)) dut_a (
      .clk10mhz(clk), .nRst(nRst), .uRx(uRx), .busDefault(bus_def[7:0]),
      .busNow(bus_now_a), .rxData8(data_a), .rxValid(valid_a),
      .rxFrameErr(ferr_a), .cfgUpdated(upd_a)
   );

   uart_rx_set_config #(.BIT_DIV(BIT_DIV), .busWIDTH(16), .TMO_BITS(TMO_BITS)) dut_b (
      .clk10mhz(clk), .nRst(nRst), .uRx(uRx), .busDefault(bus_def),
      .busNow(bus_now_b), .rxData8(data_b), .rxValid(valid_b),
      .rxFrameErr(ferr_b), .cfgUpdated(upd_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_bus(input int n);
      logic [31:0] v;
      v = m_usedef[n] ? {16'b0, bus_def} : m_cfg[n];
      return v & ((32'h1 << width_of[n]) - 32'h1);
   endfunction

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         m_usedef[n]  = 1'b1;
         m_collect[n] = 1'b0;
         m_got[n]     = 0;
         m_stage[n]   = '0;
         m_cfg[n]     = '0;
      end
      m_data = 8'h00;
   endtask

   task automatic model_event(input int n, input logic [7:0] b, input bit ferr,
                              input bit long_gap, output bit upd);
      int nb;
      nb  = (width_of[n] + 7) / 8;
      upd = 1'b0;
      if (long_gap) m_collect[n] = 1'b0;
      if (ferr) begin
         m_collect[n] = 1'b0;
      end else if (!m_collect[n]) begin
         if (b == 8'h53) begin
            m_collect[n] = 1'b1;
            m_got[n]     = 0;
            m_stage[n]   = '0;
         end else if (b == 8'h44) begin
            m_usedef[n] = 1'b1;
            upd         = 1'b1;
         end
      end else begin
         m_stage[n] = m_stage[n] | (32'(b) << (8 * m_got[n]));
         m_got[n]++;
         if (m_got[n] == nb) begin
            m_cfg[n]     = m_stage[n] & ((32'h1 << width_of[n]) - 32'h1);
            m_usedef[n]  = 1'b0;
            upd          = 1'b1;
            m_collect[n] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (nRst) begin
         if (valid_a) cnt_va++;
         if (ferr_a)  cnt_fa++;
         if (upd_a)   cnt_ua++;
         if (valid_b) cnt_vb++;
         if (ferr_b)  cnt_fb++;
         if (upd_b)   cnt_ub++;
         if (settled) begin
            chk("busNow_a", 32'(bus_now_a), exp_bus(0));
            chk("busNow_b", 32'(bus_now_b), exp_bus(1));
            chk("rxData8_a", 32'(data_a), 32'(m_data));
            chk("rxData8_b", 32'(data_b), 32'(m_data));
            chk("quiet_pulses", {26'b0, valid_a, ferr_a, upd_a, valid_b, ferr_b, upd_b}, 32'd0);
         end
      end
   end

   task automatic set_default(input logic [15:0] v);
      settled = 1'b0;
      bus_def = v;
      @(negedge clk);
      settled = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int idle);
      logic [9:0] frame;
      bit u0, u1;
      int va, fa, ua, vb, fb, ub;
      uRx = 1'b1;
      repeat (idle) @(negedge clk);
      settled = 1'b0;
      va = cnt_va; fa = cnt_fa; ua = cnt_ua;
      vb = cnt_vb; fb = cnt_fb; ub = cnt_ub;
      frame = {stop_ok, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         uRx = frame[j];
         repeat (BIT_DIV) @(negedge clk);
      end
      uRx = 1'b1;
      model_event(0, b, !stop_ok, idle > GAP_LIMIT, u0);
      model_event(1, b, !stop_ok, idle > GAP_LIMIT, u1);
      if (stop_ok) m_data = b;
      chk("rxValid_a_count",    32'(cnt_va - va), 32'(stop_ok));
      chk("rxFrameErr_a_count", 32'(cnt_fa - fa), 32'(!stop_ok));
      chk("cfgUpdated_a_count", 32'(cnt_ua - ua), 32'(u0));
      chk("rxValid_b_count",    32'(cnt_vb - vb), 32'(stop_ok));
      chk("rxFrameErr_b_count", 32'(cnt_fb - fb), 32'(!stop_ok));
      chk("cfgUpdated_b_count", 32'(cnt_ub - ub), 32'(u1));
      settled = 1'b1;
   endtask

   initial begin
      int va, fa, idle, r;
      bit ok;
      logic [7:0] b;

      nRst = 1'b0; uRx = 1'b1; bus_def = 16'h5AA5;
      model_reset();
      repeat (5) @(negedge clk);
      chk("reset_busNow_a", 32'(bus_now_a), 32'h0000_00A5);
      chk("reset_busNow_b", 32'(bus_now_b), 32'h0000_5AA5);
      chk("reset_rxData8", 32'(data_a), 32'h0);
      chk("reset_pulses", {26'b0, valid_a, ferr_a, upd_a, valid_b, ferr_b, upd_b}, 32'd0);
      nRst = 1'b1;
      settled = 1'b1;
      repeat (200) @(negedge clk);
      chk("idle_no_activity", 32'(cnt_va + cnt_fa + cnt_ua), 32'd0);

      send_byte(8'h53, 1'b1, 20);
      send_byte(8'h3C, 1'b1, 20);
      chk("set_busNow_a", 32'(bus_now_a), 32'h3C);
      chk("set_rxData8", 32'(data_a), 32'h3C);
      send_byte(8'h77, 1'b1, 20);
      chk("set_busNow_b", 32'(bus_now_b), 32'h773C);
      set_default(16'h0F0F);
      chk("busNow_a_ignores_default", 32'(bus_now_a), 32'h3C);

      send_byte(8'h44, 1'b1, 20);
      chk("default_busNow_a", 32'(bus_now_a), 32'h0F);
      chk("default_busNow_b", 32'(bus_now_b), 32'h0F0F);

      send_byte(8'h53, 1'b0, 20);
      send_byte(8'h53, 1'b1, 20);
      send_byte(8'h11, 1'b1, 20);
      chk("after_ferr_busNow_a", 32'(bus_now_a), 32'h11);
      send_byte(8'h22, 1'b1, 20);
      chk("after_ferr_busNow_b", 32'(bus_now_b), 32'h2211);

      send_byte(8'h53, 1'b1, 20);
      send_byte(8'h34, 1'b1, 20);
      send_byte(8'h12, 1'b1, 2000);
      chk("timeout_busNow_b", 32'(bus_now_b), 32'h2211);
      send_byte(8'h53, 1'b1, 20);
      send_byte(8'h34, 1'b1, 20);
      send_byte(8'h12, 1'b1, 20);
      chk("full16_busNow_b", 32'(bus_now_b), 32'h1234);
      chk("full16_busNow_a", 32'(bus_now_a), 32'h34);

      va = cnt_va; fa = cnt_fa;
      uRx = 1'b0;
      repeat (40) @(negedge clk);
      uRx = 1'b1;
      repeat (300) @(negedge clk);
      chk("glitch_pulses", 32'((cnt_va - va) + (cnt_fa - fa)), 32'd0);
      send_byte(8'hC3, 1'b1, 20);
      chk("after_glitch_rxData8", 32'(data_a), 32'hC3);

      settled = 1'b0;
      uRx = 1'b0;
      repeat (300) @(negedge clk);
      nRst = 1'b0;
      uRx = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      chk("midreset_busNow_a", 32'(bus_now_a), 32'h0F);
      chk("midreset_busNow_b", 32'(bus_now_b), 32'h0F0F);
      chk("midreset_rxData8", 32'(data_b), 32'h0);
      chk("midreset_pulses", {26'b0, valid_a, ferr_a, upd_a, valid_b, ferr_b, upd_b}, 32'd0);
      nRst = 1'b1;
      repeat (10) @(negedge clk);
      settled = 1'b1;
      send_byte(8'h5A, 1'b1, 20);
      chk("after_reset_rxData8", 32'(data_a), 32'h5A);

      for (int i = 0; i < 45; i++) begin
         r = $urandom_range(0, 99);
         if (r < 25)      b = 8'h53;
         else if (r < 37) b = 8'h44;
         else             b = 8'($urandom);
         ok = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 4) == 0) idle = $urandom_range(1000, 1500);
         else                           idle = $urandom_range(3, 300);
         if ($urandom_range(0, 5) == 0) set_default(16'($urandom));
         send_byte(b, ok, idle);
      end
      repeat (50) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
